// File: rtl/alu_seq_ctrl.sv
// Sequenced ALU front-end: A, B and the opcode are entered one after another on data_in.
// Each rising edge of 'enter' advances the entry FSM by one step. The result and flags
// are registered when the opcode is accepted.
// Optional feature macro: ALU_SEQ_CHAIN_EN. When it is defined, an enter edge while the
// result is shown loads A from the result and jumps straight to B entry.
module alu_seq_ctrl #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         enter,
  input  logic         clear,
  output logic [N-1:0] result,
  output logic [4:0]   flags,
  output logic         res_valid,
  output logic [3:0]   state_leds,
  output logic [N-1:0] display
);

  typedef enum logic [1:0] {
    StWaitA   = 2'd0,
    StWaitB   = 2'd1,
    StWaitOp  = 2'd2,
    StShowRes = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic [N-1:0]   result_q, result_d;
  logic [4:0]     flags_q, flags_d;
  logic           enter_q;
  logic           ev;

  // ALU signals
  logic [2:0]     alu_op;
  logic [N:0]     add_full;
  logic [N:0]     sub_full;
  logic [N-1:0]   alu_res;
  logic           alu_c;
  logic           alu_v;
  logic [4:0]     alu_flags;

  assign ev = enter & ~enter_q;

  // The live opcode feeds the ALU while it is being entered; otherwise the stored one does.
  assign alu_op = (state_q == StWaitOp) ? data_in[2:0] : op_q;

  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  // Subtraction as A + ~B + 1 so the carry out means "no borrow".
  assign sub_full = {1'b0, a_q} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};

  // Combinational ALU: result, carry and signed overflow for the selected operation
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (alu_op)
      3'b000: begin
        alu_res = add_full[N-1:0];
        alu_c   = add_full[N];
        alu_v   = (a_q[N-1] == b_q[N-1]) && (add_full[N-1] != a_q[N-1]);
      end
      3'b001: begin
        alu_res = sub_full[N-1:0];
        alu_c   = sub_full[N];
        alu_v   = (a_q[N-1] != b_q[N-1]) && (sub_full[N-1] != a_q[N-1]);
      end
      3'b010: alu_res = a_q & b_q;
      3'b011: alu_res = a_q | b_q;
      3'b100: alu_res = a_q ^ b_q;
      3'b101: begin
        alu_res = {a_q[N-2:0], 1'b0};
        alu_c   = a_q[N-1];
      end
      3'b110: begin
        alu_res = {1'b0, a_q[N-1:1]};
        alu_c   = a_q[0];
      end
      default: alu_res = a_q;
    endcase
  end

  // Flags packed as {N, Z, C, V, P}
  assign alu_flags = {alu_res[N-1], (alu_res == '0), alu_c, alu_v, ^alu_res};

  // Next-state and register-load logic; clear overrides any enter edge
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (clear) begin
      state_d = StWaitA;
    end else if (ev) begin
      unique case (state_q)
        StWaitA: begin
          a_d     = data_in;
          state_d = StWaitB;
        end
        StWaitB: begin
          b_d     = data_in;
          state_d = StWaitOp;
        end
        StWaitOp: begin
          op_d     = data_in[2:0];
          result_d = alu_res;
          flags_d  = alu_flags;
          state_d  = StShowRes;
        end
        StShowRes: begin
`ifdef ALU_SEQ_CHAIN_EN
          a_d     = result_q;
          state_d = StWaitB;
`else
          state_d = StWaitA;
`endif
        end
        default: state_d = StWaitA;
      endcase
    end
  end

  // State, operand and result registers; enter history resets high to reject a held enter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StWaitA;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      enter_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      enter_q  <= enter;
    end
  end

  // Output decode: one-hot state LEDs and display source select
  always_comb begin
    state_leds = 4'b0001;
    res_valid  = 1'b0;
    display    = data_in;
    unique case (state_q)
      StWaitA:   state_leds = 4'b0001;
      StWaitB:   state_leds = 4'b0010;
      StWaitOp:  state_leds = 4'b0100;
      StShowRes: begin
        state_leds = 4'b1000;
        res_valid  = 1'b1;
        display    = result_q;
      end
      default:   state_leds = 4'b0001;
    endcase
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (N=16): a vector table of known calculations,
// randomized calculations against an arithmetic reference model, and hand-written
// sequences for reset, held enter, clear priority and the result-chaining option.
module tb_alu_seq_ctrl;

  localparam int unsigned N = 16;

  logic         clk;
  logic         reset;
  logic [N-1:0] data_in;
  logic         enter;
  logic         clear;
  logic [N-1:0] result;
  logic [4:0]   flags;
  logic         res_valid;
  logic [3:0]   state_leds;
  logic [N-1:0] display;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .enter     (enter),
    .clear     (clear),
    .result    (result),
    .flags     (flags),
    .res_valid (res_valid),
    .state_leds(state_leds),
    .display   (display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] exp_res;
    logic [4:0]  exp_flags;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One enter press: rising edge for one cycle, then released for one cycle
  task automatic press(input logic [15:0] d);
    data_in = d;
    enter   = 1'b1;
    tick();
    enter   = 1'b0;
    tick();
  endtask

  task automatic go_wait_a();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Reference: {result, N, Z, C, V, P} from plain integer arithmetic
  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r = 0;
    int sr;
    bit c = 0;
    bit v = 0;
    logic [15:0] res;
    case (op)
      3'd0: begin
        r = ua + ub;
        c = (r > 65535);
        sr = sa + sb;
        v = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        r = ua - ub;
        c = (ua >= ub);
        sr = sa - sb;
        v = (sr > 32767) || (sr < -32768);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin
        r = ua * 2;
        c = (ua >= 32768);
      end
      3'd6: begin
        r = ua / 2;
        c = (ua % 2) == 1;
      end
      default: r = ua;
    endcase
    res = 16'(r & 32'hFFFF);
    return {res, res[15], (res == 16'h0), c, v, 1'(($countones(res) % 2))};
  endfunction

  // Full entry of A, B, op from S_WAIT_A; checks the result one cycle after the op edge
  task automatic do_calc(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [15:0] er, input logic [4:0] ef);
    go_wait_a();
    press(a);
    press(b);
    data_in = {13'd0, op};
    enter   = 1'b1;
    tick();
    chk({name, " result"}, 32'(result), 32'(er));
    chk({name, " flags"}, 32'(flags), 32'(ef));
    chk({name, " valid"}, 32'(res_valid), 32'd1);
    chk({name, " display"}, 32'(display), 32'(er));
    enter = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [2:0]  rop;
    logic [20:0] m;

    vecs[0]  = '{16'h7FFF, 16'h0001, 3'd0, 16'h8000, 5'b10011};
    vecs[1]  = '{16'h0005, 16'h0005, 3'd1, 16'h0000, 5'b01100};
    vecs[2]  = '{16'h0003, 16'h0005, 3'd1, 16'hFFFE, 5'b10001};
    vecs[3]  = '{16'h8001, 16'h1234, 3'd5, 16'h0002, 5'b00101};
    vecs[4]  = '{16'h8001, 16'h1234, 3'd6, 16'h4000, 5'b00101};
    vecs[5]  = '{16'hF0F0, 16'h0FF0, 3'd2, 16'h00F0, 5'b00000};
    vecs[6]  = '{16'hF0F0, 16'h0F0F, 3'd3, 16'hFFFF, 5'b10000};
    vecs[7]  = '{16'hAAAA, 16'hAAAA, 3'd4, 16'h0000, 5'b01000};
    vecs[8]  = '{16'h1234, 16'h0000, 3'd7, 16'h1234, 5'b00001};
    vecs[9]  = '{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 5'b01100};
    vecs[10] = '{16'h8000, 16'h0001, 3'd1, 16'h7FFF, 5'b00111};

    reset   = 1'b1;
    enter   = 1'b0;
    clear   = 1'b0;
    data_in = 16'h5A5A;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("reset leds", 32'(state_leds), 32'h1);
    chk("reset result", 32'(result), 32'h0);
    chk("reset flags", 32'(flags), 32'h0);
    chk("reset valid", 32'(res_valid), 32'h0);
    chk("reset display", 32'(display), 32'h5A5A);

    for (int i = 0; i < 11; i++) begin
      do_calc($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
              vecs[i].exp_res, vecs[i].exp_flags);
    end

    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 3'($urandom_range(7, 0));
      m   = model(ra, rb, rop);
      do_calc($sformatf("rand%0d op%0d", i, rop), ra, rb, rop, m[20:5], m[4:0]);
    end

    // Result held after leaving S_SHOW_RES, display follows data_in again
    go_wait_a();
    data_in = 16'h0F0F;
    tick();
    chk("held result", 32'(result), 32'(m[20:5]));
    chk("wait display", 32'(display), 32'h0F0F);
    chk("wait valid", 32'(res_valid), 32'h0);

    // Reset mid-entry with enter held through and past reset
    do_calc("pre-reset", 16'h1111, 16'h2222, 3'd0, 16'h3333, 5'b00000);
    go_wait_a();
    press(16'h0001);
    press(16'h0002);
    chk("in wait_op", 32'(state_leds), 32'h4);
    enter = 1'b1;
    reset = 1'b1;
    tick();
    chk("mid reset leds", 32'(state_leds), 32'h1);
    chk("mid reset result", 32'(result), 32'h0);
    chk("mid reset flags", 32'(flags), 32'h0);
    chk("mid reset valid", 32'(res_valid), 32'h0);
    reset = 1'b0;
    tick();
    chk("held enter after reset", 32'(state_leds), 32'h1);
    enter = 1'b0;
    tick();

    // Held enter advances exactly one step
    data_in = 16'h0007;
    enter   = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("held enter one step", 32'(state_leds), 32'h2);
    enter = 1'b0;
    tick();

    // clear and enter edge together from S_WAIT_B: clear wins
    clear = 1'b1;
    enter = 1'b1;
    tick();
    chk("clear beats enter", 32'(state_leds), 32'h1);
    clear = 1'b0;
    tick();
    chk("no late edge", 32'(state_leds), 32'h1);
    enter = 1'b0;
    tick();

    // Enter edge in S_SHOW_RES: chain or return to S_WAIT_A
    do_calc("chain base", 16'h0002, 16'h0003, 3'd0, 16'h0005, 5'b00000);
    press(16'hDEAD);
`ifdef ALU_SEQ_CHAIN_EN
    chk("chain to wait_b", 32'(state_leds), 32'h2);
    press(16'h0004);
    data_in = 16'h0000;
    enter   = 1'b1;
    tick();
    chk("chain result", 32'(result), 32'h0009);
    chk("chain valid", 32'(res_valid), 32'h1);
    enter = 1'b0;
    tick();
`else
    chk("show_res to wait_a", 32'(state_leds), 32'h1);
    press(16'h0004);
    chk("fresh A entry", 32'(state_leds), 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
